seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one combinational 7-segment decoder (the per-segment a..g decoder set) among NUM_DIGITS display digits. It holds a per-digit BCD register bank written through a valid/ready port, presents one digit's code at a time to the shared decoder, and registers the returned segment pattern. It drives a one-hot digit select with a blanking gap between digits to prevent ghosting. It sits between the host/count logic and the display driver pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_scan_ctrl_if.sv | 34 +++
 rtl/seg_dwell_timer.sv | 34 +++
 rtl/seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment scan controller.
//   scan_state_t : scan FSM states
//   bcd_t        : one BCD digit code
//   BCD_MAX      : largest displayable code; anything above it is a decoder don't-care
//   SEG_W        : segment vector width {g,f,e,d,c,b,a}
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_SHOW    = 2'd3
  } scan_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam int   SEG_W   = 7;

  function automatic logic bcd_valid(input bcd_t code);
    return (code <= BCD_MAX);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: valid/ready write port into the per-digit BCD bank.
//   wr_valid : host requests a write
//   wr_ready : bank can accept (low only while a digit is being presented)
//   wr_digit : target digit index
//   wr_code  : BCD code to store
// Modports: master = host side, slave = scan controller side.
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  localparam int DIG_W = $clog2(NUM_DIGITS);

  logic             wr_valid;
  logic             wr_ready;
  logic [DIG_W-1:0] wr_digit;
  bcd_t             wr_code;

  modport master (
    output wr_valid,
    output wr_digit,
    output wr_code,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_digit,
    input  wr_code,
    output wr_ready
  );

endinterface

// File: rtl/seg_dwell_timer.sv
// seg_dwell_timer: loadable down-counter shared by the blank and dwell phases.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_val this cycle (takes priority over counting)
//   i_load_val  : value loaded; the phase lasts i_load_val+1 cycles
//   o_count     : current count
//   o_tc        : terminal count, high while the count is zero
// The counter holds at zero until reloaded.
module seg_dwell_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller.
// Shares one external combinational decoder among NUM_DIGITS digits: each digit
// gets a blanking gap, one cycle presenting its code to the decoder, then a
// dwell with the registered segment pattern and its one-hot digit select lit.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   enable     : scan run; low returns to IDLE (bank retained)
//   wr         : seg_scan_ctrl_if.slave write port into the digit bank
//   dec_in     : code driven to the shared decoder (valid during PRESENT)
//   dec_seg    : decoder result {g,f,e,d,c,b,a}
//   seg_out    : registered segment drive
//   dig_sel    : one-hot digit enable, active high
//   scan_done  : one-cycle pulse in the last dwell cycle of the top digit
//   err_code   : sticky, a code above 9 was written
//
// Build option: SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | scan stopped, all outputs off, digit index at 0
// BLANK   | all digits off for BLANK_CYCLES to avoid ghosting
// PRESENT | one cycle: current code on dec_in, decoder result captured
// SHOW    | current digit lit for DWELL_CYCLES
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg_scan_ctrl_if.slave        wr,
  output bcd_t                  dec_in,
  input  logic [SEG_W-1:0]      dec_seg,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  scan_done,
  output logic                  err_code
);

  localparam int DIG_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [DIG_W-1:0] IDX_LAST = DIG_W'(NUM_DIGITS - 1);

  scan_state_t             r_state;
  logic [DIG_W-1:0]        r_idx;
  bcd_t                    r_bank [NUM_DIGITS];
  bcd_t                    r_dec_in;
  logic [SEG_W-1:0]        r_seg;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_done;
  logic                    r_err;
  logic                    r_wr_ready;

  logic                    w_wr_fire;
  logic                    w_wr_hit;
  bcd_t                    w_next_code;
  logic                    w_lz_blank;
  logic                    w_suppress;
  logic                    w_tmr_load;
  logic [CNT_W-1:0]        w_tmr_val;
  logic [CNT_W-1:0]        w_tmr_count;
  logic                    w_tmr_tc;

  // Out-of-range digit indices complete the handshake but are discarded.
  assign w_wr_fire = wr.wr_valid && r_wr_ready;
  assign w_wr_hit  = w_wr_fire && (int'(wr.wr_digit) < NUM_DIGITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_bank[i] <= '0;
      end
      r_err <= 1'b0;
    end else if (w_wr_hit) begin
      r_bank[wr.wr_digit] <= wr.wr_code;
      if (!bcd_valid(wr.wr_code)) begin
        r_err <= 1'b1;
      end
    end
  end

  // A write landing on the edge that enters PRESENT must be what the decoder
  // sees, so the bank is bypassed for that digit. During PRESENT the bank is
  // frozen (wr_ready low), so suppression below sees the same code.
  assign w_next_code = (w_wr_hit && (wr.wr_digit == r_idx)) ? wr.wr_code : r_bank[r_idx];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic w_upper_zero;

  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(r_idx)) && (r_bank[i] != 4'd0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign w_lz_blank = (r_idx != '0) && w_upper_zero;
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_suppress = !bcd_valid(r_bank[r_idx]) || w_lz_blank;

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = BLANK_LD;
    if (enable) begin
      case (r_state)
        ST_IDLE:    w_tmr_load = 1'b1;
        ST_PRESENT: begin
          w_tmr_load = 1'b1;
          w_tmr_val  = DWELL_LD;
        end
        ST_SHOW:    w_tmr_load = w_tmr_tc;
        default:    w_tmr_load = 1'b0;
      endcase
    end
  end

  seg_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_count    (w_tmr_count),
    .o_tc       (w_tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_dec_in   <= '0;
      r_seg      <= '0;
      r_sel      <= '0;
      r_done     <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      r_done     <= 1'b0;
      r_wr_ready <= 1'b1;
      if (!enable) begin
        r_state  <= ST_IDLE;
        r_idx    <= '0;
        r_dec_in <= '0;
        r_seg    <= '0;
        r_sel    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_BLANK;
          end
          ST_BLANK: begin
            if (w_tmr_tc) begin
              r_state    <= ST_PRESENT;
              r_dec_in   <= bcd_valid(w_next_code) ? w_next_code : '0;
              r_wr_ready <= 1'b0;
            end
          end
          ST_PRESENT: begin
            r_state  <= ST_SHOW;
            r_dec_in <= '0;
            r_seg    <= w_suppress ? '0 : dec_seg;
            r_sel    <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
            // scan_done is registered, so it is raised on the edge entering
            // the final dwell cycle of the top digit.
            if ((DWELL_CYCLES == 1) && (r_idx == IDX_LAST)) begin
              r_done <= 1'b1;
            end
          end
          ST_SHOW: begin
            if ((w_tmr_count == CNT_W'(1)) && (r_idx == IDX_LAST)) begin
              r_done <= 1'b1;
            end
            if (w_tmr_tc) begin
              r_state <= ST_BLANK;
              r_seg   <= '0;
              r_sel   <= '0;
              r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + DIG_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign wr.wr_ready = r_wr_ready;
  assign dec_in      = r_dec_in;
  assign seg_out     = r_seg;
  assign dig_sel     = r_sel;
  assign scan_done   = r_done;
  assign err_code    = r_err;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl with
// NUM_DIGITS=4, DWELL=4, BLANK=2 and a reference 7-segment decoder.
// Cycle c is the clock period following edge c-1, where edge 0 is the first
// edge at which enable is sampled high; one digit slot is 7 cycles.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int ND = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  bcd_t          dec_in;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_out;
  logic [ND-1:0] dig_sel;
  logic          scan_done;
  logic          err_code;

  int n_pass;
  int n_total;

  bcd_t       model [ND];
  logic [3:0] cap_sel  [1:28];
  logic [6:0] cap_seg  [1:28];
  bcd_t       cap_dec  [1:28];
  logic       cap_done [1:28];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) wr_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr        (wr_if),
    .dec_in    (dec_in),
    .dec_seg   (dec_seg),
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .scan_done (scan_done),
    .err_code  (err_code)
  );

  function automatic logic [6:0] seg7(input bcd_t c);
    case (c)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb dec_seg = seg7(dec_in);

  function automatic logic [6:0] exp_seg(input int d);
    logic lead;
    lead = (d > 0);
    for (int j = d; j < ND; j++) begin
      if (model[j] != 4'd0) lead = 1'b0;
    end
    if (model[d] > 4'd9) return 7'h00;
    if (LZ_EN && lead) return 7'h00;
    return seg7(model[d]);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] d, input bcd_t code);
    logic ok;
    logic rdy;
    ok = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_digit = d;
    wr_if.wr_code  = code;
    for (int i = 0; i < 10 && !ok; i++) begin
      rdy = wr_if.wr_ready;
      step();
      if (rdy) ok = 1'b1;
    end
    wr_if.wr_valid = 1'b0;
    n_total++;
    if (!ok) $display("FAIL write_accept digit=%0d got no handshake want accepted", d);
    else begin
      n_pass++;
      model[d] = code;
    end
  endtask

  task automatic capture_frame();
    enable = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      step();
      cap_sel[c]  = dig_sel;
      cap_seg[c]  = seg_out;
      cap_dec[c]  = dec_in;
      cap_done[c] = scan_done;
    end
  endtask

  task automatic stop_scan();
    enable = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_digit = '0;
    wr_if.wr_code  = '0;
    for (int i = 0; i < ND; i++) model[i] = 4'd0;
    step();
    step();
    n_total += 6;
    if (seg_out !== 7'h00) $display("FAIL reset_seg_out got %h want 00", seg_out); else n_pass++;
    if (dig_sel !== 4'b0000) $display("FAIL reset_dig_sel got %b want 0000", dig_sel); else n_pass++;
    if (dec_in !== 4'd0) $display("FAIL reset_dec_in got %h want 0", dec_in); else n_pass++;
    if (scan_done !== 1'b0) $display("FAIL reset_scan_done got %b want 0", scan_done); else n_pass++;
    if (err_code !== 1'b0) $display("FAIL reset_err_code got %b want 0", err_code); else n_pass++;
    if (wr_if.wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", wr_if.wr_ready); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++;
    if (dig_sel !== 4'b0000) $display("FAIL idle_dig_sel got %b want 0000", dig_sel); else n_pass++;
  endtask

  task automatic test_frame_timing();
    logic [3:0] es;
    int d, p;
    capture_frame();
    for (int c = 1; c <= 28; c++) begin
      d = (c - 1) / 7;
      p = (c - 1) % 7;
      es = (p >= 3) ? (4'b0001 << d) : 4'b0000;
      n_total += 2;
      if (cap_sel[c] !== es) $display("FAIL timing_dig_sel c=%0d got %b want %b", c, cap_sel[c], es); else n_pass++;
      if (cap_done[c] !== (c == 28)) $display("FAIL timing_scan_done c=%0d got %b want %b", c, cap_done[c], (c == 28)); else n_pass++;
    end
    n_total += 2;
    if (cap_seg[4] !== 7'h3F) $display("FAIL timing_digit0_zero got %h want 3F", cap_seg[4]); else n_pass++;
    if (cap_dec[3] !== 4'd0) $display("FAIL timing_dec_in got %h want 0", cap_dec[3]); else n_pass++;
    stop_scan();
  endtask

  task automatic test_bank_scan();
    logic [3:0] es;
    logic [6:0] eg;
    int d, p;
    do_write(2'd0, 4'd2);
    do_write(2'd1, 4'd7);
    do_write(2'd2, 4'd0);
    do_write(2'd3, 4'd3);
    capture_frame();
    for (int c = 1; c <= 28; c++) begin
      d = (c - 1) / 7;
      p = (c - 1) % 7;
      es = (p >= 3) ? (4'b0001 << d) : 4'b0000;
      eg = (p >= 3) ? exp_seg(d) : 7'h00;
      n_total += 2;
      if (cap_sel[c] !== es) $display("FAIL bank_dig_sel c=%0d got %b want %b", c, cap_sel[c], es); else n_pass++;
      if (cap_seg[c] !== eg) $display("FAIL bank_seg_out c=%0d got %h want %h", c, cap_seg[c], eg); else n_pass++;
      if (p == 2) begin
        n_total++;
        if (cap_dec[c] !== model[d]) $display("FAIL bank_dec_in c=%0d got %h want %h", c, cap_dec[c], model[d]); else n_pass++;
      end
    end
    n_total += 4;
    if (cap_seg[4] !== 7'h5B) $display("FAIL bank_d0 got %h want 5B", cap_seg[4]); else n_pass++;
    if (cap_seg[11] !== 7'h07) $display("FAIL bank_d1 got %h want 07", cap_seg[11]); else n_pass++;
    if (cap_seg[18] !== 7'h3F) $display("FAIL bank_d2 got %h want 3F", cap_seg[18]); else n_pass++;
    if (cap_seg[25] !== 7'h4F) $display("FAIL bank_d3 got %h want 4F", cap_seg[25]); else n_pass++;
    stop_scan();
  endtask

  task automatic test_bad_code();
    logic [3:0] es;
    logic [6:0] eg;
    int d, p;
    do_write(2'd1, 4'hB);
    n_total++;
    if (err_code !== 1'b1) $display("FAIL err_set got %b want 1", err_code); else n_pass++;
    capture_frame();
    for (int c = 1; c <= 28; c++) begin
      d = (c - 1) / 7;
      p = (c - 1) % 7;
      es = (p >= 3) ? (4'b0001 << d) : 4'b0000;
      eg = (p >= 3) ? exp_seg(d) : 7'h00;
      n_total += 2;
      if (cap_sel[c] !== es) $display("FAIL bad_dig_sel c=%0d got %b want %b", c, cap_sel[c], es); else n_pass++;
      if (cap_seg[c] !== eg) $display("FAIL bad_seg_out c=%0d got %h want %h", c, cap_seg[c], eg); else n_pass++;
    end
    n_total += 3;
    if (cap_dec[10] !== 4'd0) $display("FAIL bad_dec_in got %h want 0", cap_dec[10]); else n_pass++;
    if (cap_seg[12] !== 7'h00) $display("FAIL bad_seg_blank got %h want 00", cap_seg[12]); else n_pass++;
    if (cap_seg[25] !== 7'h4F) $display("FAIL bad_other_digit got %h want 4F", cap_seg[25]); else n_pass++;
    stop_scan();
    do_write(2'd1, 4'd7);
    n_total++;
    if (err_code !== 1'b1) $display("FAIL err_sticky got %b want 1", err_code); else n_pass++;
  endtask

  task automatic test_write_present();
    int cyc;
    enable = 1'b1;
    for (cyc = 1; cyc <= 3; cyc++) step();
    cyc = 3;
    n_total += 2;
    if (wr_if.wr_ready !== 1'b0) $display("FAIL ready_in_present got %b want 0", wr_if.wr_ready); else n_pass++;
    if (dec_in !== 4'd2) $display("FAIL present_dec_in got %h want 2", dec_in); else n_pass++;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_digit = 2'd2;
    wr_if.wr_code  = 4'd5;
    step();
    cyc = 4;
    n_total += 3;
    if (wr_if.wr_ready !== 1'b1) $display("FAIL ready_after_present got %b want 1", wr_if.wr_ready); else n_pass++;
    if (dig_sel !== 4'b0001) $display("FAIL wp_dig_sel got %b want 0001", dig_sel); else n_pass++;
    if (seg_out !== 7'h5B) $display("FAIL wp_seg_d0 got %h want 5B", seg_out); else n_pass++;
    step();
    cyc = 5;
    wr_if.wr_digit = 2'd0;
    wr_if.wr_code  = 4'd8;
    step();
    cyc = 6;
    wr_if.wr_valid = 1'b0;
    n_total++;
    if (seg_out !== 7'h5B) $display("FAIL lit_digit_held got %h want 5B", seg_out); else n_pass++;
    while (cyc < 17) begin step(); cyc++; end
    n_total++;
    if (dec_in !== 4'd5) $display("FAIL late_write_dec_in got %h want 5", dec_in); else n_pass++;
    step();
    cyc++;
    n_total += 2;
    if (dig_sel !== 4'b0100) $display("FAIL wp_dig_sel_d2 got %b want 0100", dig_sel); else n_pass++;
    if (seg_out !== 7'h6D) $display("FAIL wp_seg_d2 got %h want 6D", seg_out); else n_pass++;
    while (cyc < 32) begin step(); cyc++; end
    n_total += 2;
    if (dig_sel !== 4'b0001) $display("FAIL next_frame_sel got %b want 0001", dig_sel); else n_pass++;
    if (seg_out !== 7'h7F) $display("FAIL next_frame_seg got %h want 7F", seg_out); else n_pass++;
    model[2] = 4'd5;
    model[0] = 4'd8;
    stop_scan();
  endtask

  task automatic test_enable_drop();
    logic [3:0] es;
    logic [6:0] eg;
    int d, p;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_total++;
    if (dig_sel !== 4'b0001) $display("FAIL drop_before got %b want 0001", dig_sel); else n_pass++;
    enable = 1'b0;
    step();
    n_total += 3;
    if (dig_sel !== 4'b0000) $display("FAIL drop_dig_sel got %b want 0000", dig_sel); else n_pass++;
    if (seg_out !== 7'h00) $display("FAIL drop_seg_out got %h want 00", seg_out); else n_pass++;
    if (dec_in !== 4'd0) $display("FAIL drop_dec_in got %h want 0", dec_in); else n_pass++;
    capture_frame();
    for (int c = 1; c <= 28; c++) begin
      d = (c - 1) / 7;
      p = (c - 1) % 7;
      es = (p >= 3) ? (4'b0001 << d) : 4'b0000;
      eg = (p >= 3) ? exp_seg(d) : 7'h00;
      n_total += 2;
      if (cap_sel[c] !== es) $display("FAIL restart_dig_sel c=%0d got %b want %b", c, cap_sel[c], es); else n_pass++;
      if (cap_seg[c] !== eg) $display("FAIL restart_seg_out c=%0d got %h want %h", c, cap_seg[c], eg); else n_pass++;
    end
    stop_scan();
  endtask

  task automatic test_leading_zero();
    logic [3:0] es;
    logic [6:0] eg;
    logic [6:0] e_d3;
    int d, p;
    do_write(2'd3, 4'd0);
    do_write(2'd2, 4'd0);
    do_write(2'd1, 4'd5);
    do_write(2'd0, 4'd0);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    e_d3 = 7'h00;
`else
    e_d3 = 7'h3F;
`endif
    capture_frame();
    for (int c = 1; c <= 28; c++) begin
      d = (c - 1) / 7;
      p = (c - 1) % 7;
      es = (p >= 3) ? (4'b0001 << d) : 4'b0000;
      eg = (p >= 3) ? exp_seg(d) : 7'h00;
      n_total += 2;
      if (cap_sel[c] !== es) $display("FAIL lz_dig_sel c=%0d got %b want %b", c, cap_sel[c], es); else n_pass++;
      if (cap_seg[c] !== eg) $display("FAIL lz_seg_out c=%0d got %h want %h", c, cap_seg[c], eg); else n_pass++;
    end
    n_total += 4;
    if (cap_seg[25] !== e_d3) $display("FAIL lz_digit3 got %h want %h", cap_seg[25], e_d3); else n_pass++;
    if (cap_sel[25] !== 4'b1000) $display("FAIL lz_digit3_sel got %b want 1000", cap_sel[25]); else n_pass++;
    if (cap_seg[11] !== 7'h6D) $display("FAIL lz_digit1 got %h want 6D", cap_seg[11]); else n_pass++;
    if (cap_seg[4] !== 7'h3F) $display("FAIL lz_digit0 got %h want 3F", cap_seg[4]); else n_pass++;
    stop_scan();
  endtask

  task automatic test_async_reset();
    do_write(2'd0, 4'd6);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_total++;
    if (seg_out !== 7'h7D) $display("FAIL pre_reset_seg got %h want 7D", seg_out); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total += 4;
    if (dig_sel !== 4'b0000) $display("FAIL async_dig_sel got %b want 0000", dig_sel); else n_pass++;
    if (seg_out !== 7'h00) $display("FAIL async_seg_out got %h want 00", seg_out); else n_pass++;
    if (err_code !== 1'b0) $display("FAIL async_err_code got %b want 0", err_code); else n_pass++;
    if (wr_if.wr_ready !== 1'b1) $display("FAIL async_wr_ready got %b want 1", wr_if.wr_ready); else n_pass++;
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < ND; i++) model[i] = 4'd0;
    step();
    capture_frame();
    n_total += 2;
    if (cap_seg[4] !== 7'h3F) $display("FAIL bank_cleared got %h want 3F", cap_seg[4]); else n_pass++;
    if (cap_sel[4] !== 4'b0001) $display("FAIL post_reset_sel got %b want 0001", cap_sel[4]); else n_pass++;
    stop_scan();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_frame_timing();
    test_bank_scan();
    test_bad_code();
    test_write_present();
    test_enable_drop();
    test_leading_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
